// File: rtl/uart_tx_ctrl_if.sv
// Host/serializer-side handshake bundle for the UART transmit frame sequencer.
// master = requester and observer of the frame, slave = the sequencer itself.
interface uart_tx_ctrl_if;
  logic       data_valid;
  logic       par_en;
  logic       data_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;

  modport master (
    output data_valid, par_en,
    input  data_load, ser_en, mux_sel, busy
  );

  modport slave (
    input  data_valid, par_en,
    output data_load, ser_en, mux_sel, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steps the output mux through start, data,
// optional parity and stop slots, and strobes the serializer load/shift.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  localparam int unsigned CNT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             accept;

  // Accept only while idle or in the final stop slot; gated by reset so no
  // load strobe escapes while the block is held in reset.
  always_comb begin
    accept = rst && bus.data_valid &&
             ((state_q == S_IDLE) ||
              ((state_q == S_STOP) && (bit_cnt_q == STOP_LAST)));
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (accept) begin
          state_d  = S_START;
          par_en_d = bus.par_en;
        end
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = par_en_q ? S_PARITY : S_STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d   = S_STOP;
        bit_cnt_d = '0;
      end
      S_STOP: begin
        if (bit_cnt_q == STOP_LAST) begin
          bit_cnt_d = '0;
          if (accept) begin
            state_d  = S_START;
            par_en_d = bus.par_en;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
    end
  end

  always_comb begin
    bus.mux_sel   = 2'b11;
    bus.ser_en    = 1'b0;
    bus.busy      = 1'b0;
    bus.data_load = accept;
    case (state_q)
      S_START:  begin bus.mux_sel = 2'b00; bus.busy = 1'b1; end
      S_DATA:   begin bus.mux_sel = 2'b01; bus.busy = 1'b1; bus.ser_en = 1'b1; end
      S_PARITY: begin bus.mux_sel = 2'b10; bus.busy = 1'b1; end
      S_STOP:   begin bus.mux_sel = 2'b11; bus.busy = 1'b1; end
      default:  begin bus.mux_sel = 2'b11; bus.busy = 1'b0; end
    endcase
  end

endmodule
